// File: rtl/store_merge_unit_pkg.sv
// store_defs: definitions shared by the store path and the load-extension path.
//   KIND_*      access-size encodings (2'b11 is also treated as a byte access)
//   state_t     store FSM states
//   misaligned  true when a word/half access does not sit on its natural boundary
package store_defs;

    localparam logic [1:0] KIND_WORD = 2'b00;
    localparam logic [1:0] KIND_HALF = 2'b01;
    localparam logic [1:0] KIND_BYTE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_MG    = 3'd2,
        ST_WR    = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    function automatic logic misaligned(input logic [1:0] kind, input logic [1:0] lane);
        return ((kind == KIND_WORD) && (lane != 2'b00)) ||
               ((kind == KIND_HALF) && lane[0]);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: combinational little-endian lane insertion.
//   i_old    current RAM word
//   i_wdata  store data (low byte/half used for sub-word stores)
//   i_kind   access size (00 word, 01 half, 1x byte)
//   i_lane   addr[1:0]; half lane selected by bit 1
//   o_merged i_old with the selected lane replaced
module store_lane_merge
    import store_defs::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_kind,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_merged
);

    always_comb begin
        o_merged = i_old;
        if (i_kind == KIND_WORD) begin
            o_merged = i_wdata;
        end else if (i_kind == KIND_HALF) begin
            if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
            else           o_merged[15:0]  = i_wdata[15:0];
        end else begin
            case (i_lane)
                2'd0:    o_merged[7:0]   = i_wdata[7:0];
                2'd1:    o_merged[15:8]  = i_wdata[7:0];
                2'd2:    o_merged[23:16] = i_wdata[7:0];
                default: o_merged[31:24] = i_wdata[7:0];
            endcase
        end
    end

endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: writes CPU store requests into a word-wide RAM without byte
// enables. Word stores write directly; byte/half stores read-modify-write.
//   clk, rst             clock, synchronous active-high reset
//   req, addr, wdata,    store request, sampled only while idle
//   kind
//   mem_addr             word-aligned RAM address (0 while idle)
//   mem_re / mem_rdata   RAM read strobe / data (valid one cycle after mem_re)
//   mem_we / mem_wdata   RAM write strobe / merged word
//   busy                 high while a store is in flight
//   done, err            completion pulse; err flags a misaligned request
module store_merge_unit
    import store_defs::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic [1:0]    kind,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        r_state;
    logic [1:0]    r_lane;
    logic [1:0]    r_kind;
    logic [15:0]   r_wdata;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_re;
    logic          r_we;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [DW-1:0] w_merged;

    store_lane_merge u_merge (
        .i_old    (mem_rdata),
        .i_wdata  ({16'h0000, r_wdata}),
        .i_kind   (r_kind),
        .i_lane   (r_lane),
        .o_merged (w_merged)
    );

    // Outputs are registered on the transition into the state that owns them,
    // so each strobe is high exactly during its state. r_mem_wdata doubles as
    // the merge register: loaded with wdata for word stores, merged word in MG.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_lane      <= '0;
            r_kind      <= '0;
            r_wdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_re        <= 1'b0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_re   <= 1'b0;
            r_we   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_lane     <= addr[1:0];
                        r_kind     <= kind;
                        r_wdata    <= wdata[15:0];
                        r_mem_addr <= {addr[AW-1:2], 2'b00};
                        r_busy     <= 1'b1;
                        if (misaligned(kind, addr[1:0])) begin
                            r_state <= ST_FAULT;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (kind == KIND_WORD) begin
                            r_state     <= ST_WR;
                            r_we        <= 1'b1;
                            r_done      <= 1'b1;
                            r_mem_wdata <= wdata;
                        end else begin
                            r_state <= ST_RD;
                            r_re    <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    r_state <= ST_MG;
                end
                ST_MG: begin
                    r_mem_wdata <= w_merged;
                    r_state     <= ST_WR;
                    r_we        <= 1'b1;
                    r_done      <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_re    = r_re;
    assign mem_we    = r_we;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        rst, req;
    logic [31:0] addr, wdata, mem_addr, mem_rdata, mem_wdata;
    logic [1:0]  kind;
    logic        mem_re, mem_we, busy, done, err;

    always #5 clk = ~clk;

    store_merge_unit #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr      (addr),
        .wdata     (wdata),
        .kind      (kind),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Bench-side RAM: 64 words indexed by address bits [7:2].
    logic [31:0] ram [64];
    logic [31:0] shadow [64];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;

    always @(posedge clk) begin
        if (pl_en)       ram[pl_idx] <= pl_val;
        else if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
        if (mem_re)      mem_rdata <= ram[mem_addr[7:2]];
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [5:0] i, input logic [31:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = i; pl_val = v;
        @(posedge clk);
        #1 pl_en = 1'b0;
        shadow[i] = v;
    endtask

    // Reference: byte-array view of the word, little-endian lanes.
    function automatic logic [31:0] ref_store(logic [31:0] old, logic [31:0] a,
                                              logic [31:0] d, logic [1:0] k);
        logic [7:0] b [4];
        int lane;
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        lane = int'(a % 4);
        if (k == 2'b00) return d;
        if (k == 2'b01) begin
            lane = (lane / 2) * 2;
            b[lane]   = d[7:0];
            b[lane+1] = d[15:8];
        end else begin
            b[lane] = d[7:0];
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic logic ref_err(logic [31:0] a, logic [1:0] k);
        return ((k == 2'b00) && (a % 4 != 0)) || ((k == 2'b01) && (a % 2 != 0));
    endfunction

    // Issues one request and watches it for up to 8 cycles; returns at the
    // negedge of the cycle in which done was seen.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] k,
                            output int lat, output int re_cyc, output int we_cyc,
                            output int n_re, output int n_we, output logic [31:0] wd,
                            output logic e, output logic [31:0] maddr, output logic busy_ok);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("done_pulse", 32'(done), 32'd0);
        req = 1'b1; addr = a; wdata = d; kind = k;
        @(posedge clk);
        #1 req = 1'b0;
        lat = -1; re_cyc = -1; we_cyc = -1; n_re = 0; n_we = 0;
        wd = '0; e = 1'b0; maddr = '0; busy_ok = 1'b1;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (c == 1) maddr = mem_addr;
            if (mem_re) begin n_re++; re_cyc = c; end
            if (mem_we) begin n_we++; we_cyc = c; wd = mem_wdata; end
            if (done)   begin lat = c; e = err; end
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  k;
        logic [31:0] init;
        logic [31:0] exp_word;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tv [10];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, re_cyc, we_cyc, n_re, n_we, we_seen, done_seen;
        logic [31:0] wd, maddr, a, d, old, expw;
        logic [1:0]  k;
        logic        e, bok, xe;
        logic [5:0]  idx;

        tv[0] = '{32'h10, 32'hCAFEF00D, 2'b00, 32'hAABBCCDD, 32'hCAFEF00D, 1'b0, 1};
        tv[1] = '{32'h11, 32'h12345678, 2'b10, 32'hAABBCCDD, 32'hAABB78DD, 1'b0, 3};
        tv[2] = '{32'h12, 32'h0000BEEF, 2'b01, 32'hAABBCCDD, 32'hBEEFCCDD, 1'b0, 3};
        tv[3] = '{32'h10, 32'h12345678, 2'b10, 32'hAABBCCDD, 32'hAABBCC78, 1'b0, 3};
        tv[4] = '{32'h12, 32'h12345678, 2'b10, 32'hAABBCCDD, 32'hAA78CCDD, 1'b0, 3};
        tv[5] = '{32'h13, 32'h12345678, 2'b10, 32'hAABBCCDD, 32'h78BBCCDD, 1'b0, 3};
        tv[6] = '{32'h10, 32'h0000BEEF, 2'b01, 32'hAABBCCDD, 32'hAABBBEEF, 1'b0, 3};
        tv[7] = '{32'h13, 32'h0000BEEF, 2'b01, 32'hAABBCCDD, 32'hAABBCCDD, 1'b1, 1};
        tv[8] = '{32'h16, 32'hCAFEF00D, 2'b00, 32'hAABBCCDD, 32'hAABBCCDD, 1'b1, 1};
        tv[9] = '{32'h11, 32'h12345678, 2'b11, 32'hAABBCCDD, 32'hAABB78DD, 1'b0, 3};

        rst = 1'b1; req = 1'b0; addr = '0; wdata = '0; kind = '0; pl_en = 1'b0;
        pl_idx = '0; pl_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            preload(tv[i].a[7:2], tv[i].init);
            do_store(tv[i].a, tv[i].d, tv[i].k, lat, re_cyc, we_cyc, n_re, n_we, wd, e, maddr, bok);
            @(posedge clk); #1;
            chk("tv_latency", 32'(lat), 32'(tv[i].exp_lat));
            chk("tv_err", 32'(e), 32'(tv[i].exp_err));
            chk("tv_n_we", 32'(n_we), tv[i].exp_err ? 32'd0 : 32'd1);
            chk("tv_n_re", 32'(n_re), (tv[i].exp_err || tv[i].k == 2'b00) ? 32'd0 : 32'd1);
            if (n_re > 0) chk("tv_re_cycle", 32'(re_cyc), 32'd1);
            if (n_we > 0) chk("tv_we_cycle", 32'(we_cyc), 32'(tv[i].exp_lat));
            chk("tv_mem_addr", maddr, {tv[i].a[31:2], 2'b00});
            chk("tv_busy", 32'(bok), 32'd1);
            chk("tv_ram", ram[tv[i].a[7:2]], tv[i].exp_word);
        end

        // Reset in the MG cycle drops the store
        preload(6'd4, 32'hAABBCCDD);
        @(negedge clk);
        req = 1'b1; addr = 32'h11; kind = 2'b10; wdata = 32'h12345678;
        @(posedge clk); #1 req = 1'b0;
        we_seen = 0; done_seen = 0;
        @(negedge clk);
        chk("rstmid_re_in_rd", 32'(mem_re), 32'd1);
        @(negedge clk);
        if (mem_we) we_seen++;
        if (done) done_seen++;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 5; c++) begin
            if (mem_we) we_seen++;
            if (done) done_seen++;
            @(negedge clk);
        end
        chk("rstmid_no_we", 32'(we_seen), 32'd0);
        chk("rstmid_no_done", 32'(done_seen), 32'd0);
        chk("rstmid_ram", ram[4], 32'hAABBCCDD);

        // rst and req together: request lost
        rst = 1'b1; req = 1'b1; addr = 32'h10; kind = 2'b00; wdata = 32'h55555555;
        @(posedge clk); #1 rst = 1'b0; req = 1'b0;
        @(negedge clk);
        chk("rstreq_busy", 32'(busy), 32'd0);
        chk("rstreq_we", 32'(mem_we), 32'd0);

        // Request during RD is ignored; request right after done is accepted
        preload(6'd4, 32'hAABBCCDD);
        preload(6'd8, 32'h11111111);
        @(negedge clk);
        req = 1'b1; addr = 32'h11; kind = 2'b10; wdata = 32'h12345678;
        @(posedge clk); #1 req = 1'b0;
        lat = -1; n_we = 0;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin req = 1'b1; addr = 32'h20; kind = 2'b00; wdata = 32'hDEADBEEF; end
            if (c == 2) req = 1'b0;
            if (mem_we) n_we++;
            if (done) lat = c;
        end
        chk("ign_latency", 32'(lat), 32'd3);
        chk("ign_n_we", 32'(n_we), 32'd1);
        do_store(32'h20, 32'hDEADBEEF, 2'b00, lat, re_cyc, we_cyc, n_re, n_we, wd, e, maddr, bok);
        @(posedge clk); #1;
        chk("b2b_latency", 32'(lat), 32'd1);
        chk("b2b_wdata", wd, 32'hDEADBEEF);
        chk("ign_ram_merged", ram[4], 32'hAABB78DD);
        chk("b2b_ram", ram[8], 32'hDEADBEEF);

        // Randomized stores against the reference model
        for (int i = 0; i < 64; i++) preload(6'(i), $urandom());
        for (int it = 0; it < 300; it++) begin
            a = $urandom();
            d = $urandom();
            k = 2'($urandom_range(0, 3));
            idx = a[7:2];
            old = shadow[idx];
            xe = ref_err(a, k);
            expw = xe ? old : ref_store(old, a, d, k);
            do_store(a, d, k, lat, re_cyc, we_cyc, n_re, n_we, wd, e, maddr, bok);
            @(posedge clk); #1;
            chk("rnd_latency", 32'(lat), xe ? 32'd1 : (k == 2'b00 ? 32'd1 : 32'd3));
            chk("rnd_err", 32'(e), 32'(xe));
            chk("rnd_n_we", 32'(n_we), xe ? 32'd0 : 32'd1);
            chk("rnd_n_re", 32'(n_re), (xe || k == 2'b00) ? 32'd0 : 32'd1);
            chk("rnd_mem_addr", maddr, {a[31:2], 2'b00});
            chk("rnd_ram", ram[idx], expw);
            shadow[idx] = expw;
            if ($urandom_range(0, 3) == 0) repeat (2) @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
